stack_mc_controller: RTL and testbench

STACK_MC_CONTROLLER -- requirements
Module: stack_mc_controller

---
 rtl/stack_mc_controller.sv | 179 +++++++++++++++++
 tb/tb_stack_mc_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mc_controller.sv
// Multi-cycle controller for a stack machine.
// Sequences fetch, decode and execute of one instruction at a time. It drives
// single-bit datapath strobes and tracks stack occupancy so that illegal pushes
// and pops are trapped in a sticky FAULT state.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   inst[IW-1:0]        instruction register; opcode in inst[IW-1:IW-3]
//   zero                top-of-stack-is-zero flag (the datapath gates pcWriteCond with it)
//   mem_ready           memory handshake, used only in FETCH, STORE and LOAD
//   pcWrite .. tos      datapath strobes
//   AluOp[1:0]          ALU function select
//   sp_count            current stack occupancy (0..DEPTH)
//   fault               sticky overflow/underflow indication
module stack_mc_controller #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IW-1:0]            inst,
    input  logic                     zero,
    input  logic                     mem_ready,
    output logic                     pcWrite,
    output logic                     pcWriteCond,
    output logic                     pcSrc,
    output logic                     IorD,
    output logic                     memRead,
    output logic                     memWrite,
    output logic                     IrWrite,
    output logic                     MtoS,
    output logic                     ldA,
    output logic                     ldB,
    output logic                     srcA,
    output logic                     srcB,
    output logic                     push,
    output logic                     pop,
    output logic                     tos,
    output logic [1:0]               AluOp,
    output logic [$clog2(DEPTH):0]   sp_count,
    output logic                     fault
);

    localparam int unsigned SPW = $clog2(DEPTH) + 1;

    typedef enum logic [3:0] {
        StFetch, StDecode, StJmp, StJz, StPopA, StLdA, StStore, StNot,
        StPopB, StLdB, StAlu, StPushR, StLoad, StPushM, StFault
    } state_e;

    state_e           state_q, state_d;
    logic [SPW-1:0]   sp_count_q, sp_count_d;
    logic [2:0]       opcode;
    logic             unused_inputs;

    assign opcode        = inst[IW-1:IW-3];
    // The zero flag and the operand field are consumed by the datapath, not here.
    assign unused_inputs = ^{zero, inst[IW-4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            sp_count_q <= '0;
        end else begin
            state_q    <= state_d;
            sp_count_q <= sp_count_d;
        end
    end

    // Next state and strobes
    always_comb begin
        state_d     = state_q;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSrc       = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IrWrite     = 1'b0;
        MtoS        = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        srcA        = 1'b0;
        srcB        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        AluOp       = 2'b00;
        unique case (state_q)
            StFetch: begin
                memRead = 1'b1;
                srcA    = 1'b1;
                srcB    = 1'b1;
                // Reset forces FETCH; suppress the PC/IR update while it is held.
                pcWrite = mem_ready & ~rst;
                IrWrite = mem_ready & ~rst;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                tos = 1'b1;
                unique case (opcode)
                    3'b110:         state_d = StJmp;
                    3'b111:         state_d = (sp_count_q < SPW'(1)) ? StFault : StJz;
                    3'b100:         state_d = (sp_count_q == SPW'(DEPTH)) ? StFault : StLoad;
                    3'b011, 3'b101: state_d = (sp_count_q < SPW'(1)) ? StFault : StPopA;
                    default:        state_d = (sp_count_q < SPW'(2)) ? StFault : StPopA;
                endcase
            end
            StJmp: begin
                pcSrc   = 1'b1;
                pcWrite = 1'b1;
                state_d = StFetch;
            end
            StJz: begin
                pcSrc       = 1'b1;
                pcWriteCond = 1'b1;
                state_d     = StFetch;
            end
            StPopA: begin
                pop     = 1'b1;
                state_d = StLdA;
            end
            StLdA: begin
                ldA = 1'b1;
                if (opcode == 3'b101)      state_d = StStore;
                else if (opcode == 3'b011) state_d = StNot;
                else                       state_d = StPopB;
            end
            StStore: begin
                IorD     = 1'b1;
                memWrite = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StNot: begin
                AluOp   = 2'b11;
                state_d = StPushR;
            end
            StPopB: begin
                pop     = 1'b1;
                state_d = StLdB;
            end
            StLdB: begin
                ldB     = 1'b1;
                state_d = StAlu;
            end
            StAlu: begin
                AluOp   = inst[IW-2:IW-3];
                state_d = StPushR;
            end
            StPushR: begin
                push    = 1'b1;
                state_d = StFetch;
            end
            StLoad: begin
                IorD    = 1'b1;
                memRead = 1'b1;
                if (mem_ready) state_d = StPushM;
            end
            StPushM: begin
                MtoS    = 1'b1;
                push    = 1'b1;
                state_d = StFetch;
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    // Occupancy; DECODE guarantees push and pop never exceed the bounds.
    always_comb begin
        sp_count_d = sp_count_q;
        if (push)     sp_count_d = sp_count_q + 1'b1;
        else if (pop) sp_count_d = sp_count_q - 1'b1;
    end

    assign sp_count = sp_count_q;
    assign fault    = (state_q == StFault);

endmodule

// File: tb/tb_stack_mc_controller.sv
module tb_stack_mc_controller;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = 8;

    // {fault, AluOp, pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite,
    //  MtoS, ldA, ldB, srcA, srcB, push, pop, tos}
    localparam logic [17:0] E_FETCH_RDY  = {3'b000, 15'b100010100011000};
    localparam logic [17:0] E_FETCH_WAIT = {3'b000, 15'b000010000011000};
    localparam logic [17:0] E_DECODE     = {3'b000, 15'b000000000000001};
    localparam logic [17:0] E_LOAD       = {3'b000, 15'b000110000000000};
    localparam logic [17:0] E_PUSHM      = {3'b000, 15'b000000010000100};
    localparam logic [17:0] E_POP        = {3'b000, 15'b000000000000010};
    localparam logic [17:0] E_LDA        = {3'b000, 15'b000000001000000};
    localparam logic [17:0] E_LDB        = {3'b000, 15'b000000000100000};
    localparam logic [17:0] E_PUSHR      = {3'b000, 15'b000000000000100};
    localparam logic [17:0] E_JZ         = {3'b000, 15'b011000000000000};
    localparam logic [17:0] E_JMP        = {3'b000, 15'b101000000000000};
    localparam logic [17:0] E_ALU_SUB    = {3'b001, 15'b000000000000000};
    localparam logic [17:0] E_FAULT      = {3'b100, 15'b000000000000000};

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [IW-1:0] inst;
    logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite, MtoS;
    logic ldA, ldB, srcA, srcB, push, pop, tos, fault;
    logic [1:0] AluOp;
    logic [$clog2(DEPTH):0] sp_count;
    logic [17:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign obs = {fault, AluOp, pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite,
                  IrWrite, MtoS, ldA, ldB, srcA, srcB, push, pop, tos};

    stack_mc_controller #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk(clk), .rst(rst), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IrWrite(IrWrite), .MtoS(MtoS),
        .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB), .push(push), .pop(pop),
        .tos(tos), .AluOp(AluOp), .sp_count(sp_count), .fault(fault)
    );

    // Leaves the bench at a falling edge with reset just released, DUT in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        inst = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        inst = '0;
        zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (obs !== E_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs, E_FETCH_WAIT);
        end
        checks++;
        if (sp_count !== 0) begin
            errors++;
            $display("FAIL reset_sp_count: got %0d want 0", sp_count);
        end
    endtask

    task automatic test_load();
        logic [17:0] want [5];
        want = '{E_FETCH_RDY, E_DECODE, E_LOAD, E_PUSHM, E_FETCH_RDY};
        do_reset();
        inst = {3'b100, 5'($urandom)};
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL load_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
        checks++;
        if (sp_count !== 1) begin
            errors++;
            $display("FAIL load_sp_count: got %0d want 1", sp_count);
        end
    endtask

    task automatic test_binary();
        logic [17:0] want [9];
        want = '{E_FETCH_RDY, E_DECODE, E_POP, E_LDA, E_POP, E_LDB, E_ALU_SUB, E_PUSHR,
                 E_FETCH_RDY};
        do_reset();
        inst = {3'b100, 5'($urandom)};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        inst = {3'b001, 5'($urandom)};
        #1;
        checks++;
        if (sp_count !== 2) begin
            errors++;
            $display("FAIL binary_pre_sp: got %0d want 2", sp_count);
        end
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL binary_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
        checks++;
        if (sp_count !== 1) begin
            errors++;
            $display("FAIL binary_post_sp: got %0d want 1", sp_count);
        end
    endtask

    task automatic test_fetch_stall();
        logic [17:0] want [5];
        want = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_RDY, E_DECODE};
        do_reset();
        inst = {3'b110, 5'($urandom)};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = (i >= 3);
            #1;
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL stall_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_underflow();
        logic [17:0] want [7];
        want = '{E_FETCH_RDY, E_DECODE, E_FAULT, E_FAULT, E_FAULT, E_FAULT, E_FAULT};
        do_reset();
        inst = {3'b000, 5'($urandom)};
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 1) mem_ready = 1'($urandom);
            #1;
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL underflow_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH_WAIT) begin
            errors++;
            $display("FAIL underflow_reset: got %b want %b", obs, E_FETCH_WAIT);
        end
    endtask

    task automatic test_overflow();
        logic [17:0] want [4];
        want = '{E_FETCH_RDY, E_DECODE, E_FAULT, E_FAULT};
        do_reset();
        inst = {3'b100, 5'($urandom)};
        mem_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) @(negedge clk);
        #1;
        checks++;
        if (sp_count !== DEPTH) begin
            errors++;
            $display("FAIL overflow_full: got %0d want %0d", sp_count, DEPTH);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL overflow_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
        checks++;
        if (sp_count !== DEPTH) begin
            errors++;
            $display("FAIL overflow_hold: got %0d want %0d", sp_count, DEPTH);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (sp_count !== 0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL overflow_reset: sp=%0d fault=%b want sp=0 fault=0", sp_count, fault);
        end
    endtask

    task automatic test_jz();
        logic [17:0] want [4];
        want = '{E_FETCH_RDY, E_DECODE, E_JZ, E_FETCH_RDY};
        do_reset();
        inst = {3'b100, 5'($urandom)};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        inst = {3'b111, 5'($urandom)};
        zero = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL jz_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_midreset();
        logic [17:0] want [4];
        want = '{E_FETCH_RDY, E_DECODE, E_JMP, E_FETCH_RDY};
        do_reset();
        inst = {3'b100, 5'($urandom)};
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH_WAIT || sp_count !== 0) begin
            errors++;
            $display("FAIL midreset_abandon: got %b sp=%0d want %b sp=0",
                     obs, sp_count, E_FETCH_WAIT);
        end
        @(negedge clk);
        rst = 1'b0;
        inst = {3'b110, 5'($urandom)};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL midreset_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    function automatic bit legal(int op, int sp);
        if (op <= 2) return sp >= 2;
        if (op == 3 || op == 5 || op == 7) return sp >= 1;
        if (op == 4) return sp < DEPTH;
        return 1'b1;
    endfunction

    // Random legal program with random mem_ready; each instruction's effects are
    // compared with what its opcode should do to the stack and the strobes.
    task automatic test_random();
        int sp, op, pushes, pops, tos_n, cyc, done_n, want_push, want_pop;
        bit mw, pcw, pcwc, mtos, post;
        logic [1:0] prev_alu, alu_at, want_alu;
        do_reset();
        sp = 0;
        do op = $urandom_range(0, 7); while (!legal(op, sp));
        inst = {op[2:0], 5'($urandom)};
        pushes = 0; pops = 0; tos_n = 0; mw = 0; pcw = 0; pcwc = 0; mtos = 0;
        post = 0; done_n = 0; cyc = 0; prev_alu = 2'b00; alu_at = 2'b00;
        while (done_n < 40 && cyc < 3000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            mem_ready = 1'($urandom);
            #1;
            if (memRead && !IorD) begin
                if (post) begin
                    want_push = (op <= 4) ? 1 : 0;
                    want_pop  = (op <= 2) ? 2 : ((op == 3 || op == 5) ? 1 : 0);
                    want_alu  = (op <= 2) ? op[1:0] : ((op == 3) ? 2'b11 : 2'b00);
                    sp = sp + want_push - want_pop;
                    checks++;
                    if (pushes != want_push || pops != want_pop || tos_n != 1) begin
                        errors++;
                        $display("FAIL rand_stack op=%0d: push=%0d pop=%0d tos=%0d want %0d %0d 1",
                                 op, pushes, pops, tos_n, want_push, want_pop);
                    end
                    checks++;
                    if (mw != (op == 5) || pcw != (op == 6) || pcwc != (op == 7) ||
                        mtos != (op == 4)) begin
                        errors++;
                        $display("FAIL rand_strobes op=%0d: mw=%b pcw=%b pcwc=%b mtos=%b",
                                 op, mw, pcw, pcwc, mtos);
                    end
                    if (want_push == 1) begin
                        checks++;
                        if (alu_at !== want_alu) begin
                            errors++;
                            $display("FAIL rand_aluop op=%0d: got %b want %b", op, alu_at, want_alu);
                        end
                    end
                    checks++;
                    if (sp_count !== sp || fault !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_sp op=%0d: sp=%0d fault=%b want sp=%0d fault=0",
                                 op, sp_count, fault, sp);
                    end
                    done_n++;
                    do op = $urandom_range(0, 7); while (!legal(op, sp));
                    inst = {op[2:0], 5'($urandom)};
                    pushes = 0; pops = 0; tos_n = 0; mw = 0; pcw = 0; pcwc = 0; mtos = 0;
                    post = 0;
                end
                checks++;
                if (pcWrite !== mem_ready || IrWrite !== mem_ready) begin
                    errors++;
                    $display("FAIL rand_fetch: pcWrite=%b IrWrite=%b want %b",
                             pcWrite, IrWrite, mem_ready);
                end
            end else begin
                post = 1;
                pushes += int'(push);
                pops   += int'(pop);
                tos_n  += int'(tos);
                mw   |= memWrite;
                pcw  |= pcWrite;
                pcwc |= pcWriteCond;
                mtos |= MtoS;
                if (push) alu_at = prev_alu;
            end
            prev_alu = AluOp;
        end
        checks++;
        if (done_n < 40) begin
            errors++;
            $display("FAIL rand_timeout: completed %0d want 40", done_n);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_binary();
        test_fetch_stall();
        test_underflow();
        test_overflow();
        test_jz();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
